// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory responder state encoding, the fault
// code, the NOP word used for preloads, and the address fault check.
package cpu_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_RESP = 2'b10
  } mem_state_e;

  localparam logic        MEM_FAULT_CODE = 1'b1;
  localparam logic [31:0] MEM_NOP_WORD   = 32'hE1A00000;

  // An access faults when it is not word aligned or when any address bit
  // above the RAM word index is set (no wrap, no aliasing).
  function automatic logic mem_addr_fault(input logic [31:0] addr,
                                          input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 32'd2);
    return (addr[1:0] != 2'b00) || (hi != 32'h0000_0000);
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word-organised RAM with one CPU read/write port and one loader write port.
// The loader wins when both write the same word on the same edge; a read
// colliding with a loader write returns the old contents.
module mem_word_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  logic [31:0] mem [2**ADDR_W];
  logic        cpu_wr;

  assign cpu_wr = en && we && !(ld_en && (ld_addr == addr));

  // Array writes; the storage has no reset so loader writes land even during reset.
  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      mem[addr] <= wdata;
    end
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Registered read data, forced to zero whenever no read is being performed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 32'h0000_0000;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end else begin
      rdata <= 32'h0000_0000;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for CPU fetch/load/store requests: accepts one
// request at a time, waits WAIT_STATES cycles, commits the access to the
// on-chip RAM (or flags a fault) and pulses a one-cycle response.
module mem_bus_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_state_e  state_r;
  mem_state_e  state_nx;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nx;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        latch_s;
  logic        commit_s;
  logic        cur_we_s;
  logic [31:0] cur_addr_s;
  logic [31:0] cur_wdata_s;
  logic        fault_s;
  logic        ram_en_s;
  logic        rsp_valid_r;
  logic        rsp_fault_r;

  // With zero wait states the commit happens on the acceptance edge, so the
  // live bus is used; otherwise the latched request is committed.
  assign cur_we_s    = (state_r == MEM_IDLE) ? req_we    : we_r;
  assign cur_addr_s  = (state_r == MEM_IDLE) ? req_addr  : addr_r;
  assign cur_wdata_s = (state_r == MEM_IDLE) ? req_wdata : wdata_r;
  assign fault_s     = mem_addr_fault(cur_addr_s, ADDR_W);
  assign ram_en_s    = commit_s && !fault_s && !reset;

  assign req_ready = (state_r == MEM_IDLE) && !reset;
  assign rsp_valid = rsp_valid_r;
  assign rsp_fault = rsp_fault_r;

  // Next-state, wait counter and commit decode.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    latch_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      MEM_IDLE: begin
        if (req) begin
          latch_s = 1'b1;
          if (WS == 4'd0) begin
            commit_s = 1'b1;
            state_nx = MEM_RESP;
          end else begin
            cnt_nx   = WS;
            state_nx = MEM_WAIT;
          end
        end else begin
          state_nx = MEM_IDLE;
        end
      end
      MEM_WAIT: begin
        if (cnt_r == 4'd0) begin
          commit_s = 1'b1;
          state_nx = MEM_RESP;
        end else begin
          cnt_nx   = cnt_r - 4'd1;
          state_nx = MEM_WAIT;
        end
      end
      MEM_RESP: begin
        state_nx = MEM_IDLE;
      end
      default: begin
        state_nx = MEM_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // State, counter, request latch and response flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= MEM_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_fault_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      rsp_valid_r <= commit_s;
      rsp_fault_r <= (commit_s && fault_s) ? MEM_FAULT_CODE : 1'b0;
      if (latch_s) begin
        we_r    <= req_we;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

  mem_word_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .en      (ram_en_s),
    .we      (cur_we_s),
    .addr    (cur_addr_s[ADDR_W+1:2]),
    .wdata   (cur_wdata_s),
    .rdata   (rsp_rdata),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one instance with one wait state, one with
// none, both checked against a word-array reference of the memory.
module tb_mem_bus_responder;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req       [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_fault [2];
  logic        ld_en     [2];
  logic [9:0]  ld_addr   [2];
  logic [31:0] ld_data   [2];

  logic [31:0] mm [2][1024];
  int          ws [2] = '{1, 0};
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.ADDR_W(10), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .reset(reset), .req(req[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));

  mem_bus_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset), .req(req[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  // One complete access on instance d; optionally a loader write is issued
  // on the acceptance edge. Expected values come from the word array.
  task automatic access(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic ld,
                        input logic [9:0] lw, input logic [31:0] lv);
    logic        flt;
    logic [31:0] erd;
    logic [31:0] grd;
    logic        gf;
    int          lows;
    int          vcnt;
    int          lat;
    flt = (addr[1:0] != 2'b00) || (addr >= 32'd4096);
    // With wait states the loader write lands before the commit edge.
    if (ld && ws[d] != 0) mm[d][lw] = lv;
    erd = (flt || we) ? 32'h0 : mm[d][addr[11:2]];
    if (!flt && we) mm[d][addr[11:2]] = wd;
    if (ld && ws[d] == 0) mm[d][lw] = lv;
    lat = (ws[d] == 0) ? 1 : ws[d] + 2;
    @(negedge clk);
    chk(d, "ready_before_req", 32'(req_ready[d]), 32'd1);
    req[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd;
    ld_en[d] = ld; ld_addr[d] = lw; ld_data[d] = lv;
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    ld_en[d] = 1'b0;
    lows = 0; vcnt = 0; grd = 32'hFFFF_FFFF; gf = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[d]) break;
      lows++;
      if (rsp_valid[d]) begin
        vcnt++;
        grd = rsp_rdata[d];
        gf  = rsp_fault[d];
      end
    end
    chk(d, "busy_cycles", 32'(lows), 32'(lat));
    chk(d, "rsp_pulses", 32'(vcnt), 32'd1);
    chk(d, "rsp_rdata", grd, erd);
    chk(d, "rsp_fault", 32'(gf), 32'(flt));
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    int          d;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'h0; req_wdata[k] = 32'h0;
      ld_en[k] = 1'b0; ld_addr[k] = 10'h0; ld_data[k] = 32'h0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "reset_ready", 32'(req_ready[k]), 32'd0);
      chk(k, "reset_valid", 32'(rsp_valid[k]), 32'd0);
      chk(k, "reset_rdata", rsp_rdata[k], 32'd0);
      chk(k, "reset_fault", 32'(rsp_fault[k]), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk(k, "ready_after_reset", 32'(req_ready[k]), 32'd1);

    // Preload words 0..63 through the loader; word 4 holds the NOP.
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ld_en[k] = 1'b1; ld_addr[k] = 10'(w);
        ld_data[k] = (w == 4) ? MEM_NOP_WORD : $urandom;
        mm[k][w] = ld_data[k];
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) ld_en[k] = 1'b0;

    // Directed accesses on both instances
    for (int k = 0; k < 2; k++) begin
      access(k, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 10'h0, 32'h0);
      access(k, 1'b1, 32'h0000_0020, 32'hDEADBEEF, 1'b0, 10'h0, 32'h0);
      access(k, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 10'h0, 32'h0);
      access(k, 1'b0, 32'h0000_0022, 32'h0, 1'b0, 10'h0, 32'h0);
      access(k, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 10'h0, 32'h0);
      access(k, 1'b1, 32'h0000_1020, 32'h12345678, 1'b0, 10'h0, 32'h0);
      access(k, 1'b1, 32'h0000_0022, 32'h87654321, 1'b0, 10'h0, 32'h0);
      access(k, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 10'h0, 32'h0);
    end

    // Store and loader write to word 8 on the same edge: loader wins.
    access(1, 1'b1, 32'h0000_0020, 32'h1, 1'b1, 10'd8, 32'h2);
    access(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 10'h0, 32'h0);
    // Read and loader write to word 9 on the same edge: read sees old data.
    access(1, 1'b0, 32'h0000_0024, 32'h0, 1'b1, 10'd9, 32'h55AA_33CC);
    access(1, 1'b0, 32'h0000_0024, 32'h0, 1'b0, 10'h0, 32'h0);

    // req held high with zero wait states: accepted every second cycle.
    @(negedge clk);
    chk(1, "b2b_ready_start", 32'(req_ready[1]), 32'd1);
    req[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0000_0010;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk(1, "b2b_valid", 32'(rsp_valid[1]), 32'(i % 2));
      chk(1, "b2b_ready", 32'(req_ready[1]), 32'((i + 1) % 2));
      if (rsp_valid[1]) chk(1, "b2b_rdata", rsp_rdata[1], mm[1][4]);
    end
    req[1] = 1'b0;

    // Randomized accesses, including loader collisions on the no-wait instance.
    for (int n = 0; n < 60; n++) begin
      d = n % 2;
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 32'($urandom_range(0, 63)) << 2;
      else if (sel < 8) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else              a = ($urandom & 32'hFFFF_FFFC) | (32'h1 << $urandom_range(12, 31));
      if (d == 1 && $urandom_range(0, 3) == 0)
        access(d, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, 10'($urandom_range(0, 63)), $urandom);
      else
        access(d, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, 10'h0, 32'h0);
    end

    // Reset while a store of 32'hCAFEF00D to 0x40 is waiting: store is dropped.
    @(negedge clk);
    chk(0, "midreset_ready_idle", 32'(req_ready[0]), 32'd1);
    req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0000_0040; req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    chk(0, "midreset_in_wait", 32'(req_ready[0]), 32'd0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk(0, "midreset_no_valid", 32'(rsp_valid[0]), 32'd0);
      chk(0, "midreset_ready_low", 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "postreset_ready", 32'(req_ready[k]), 32'd1);
      chk(k, "postreset_valid", 32'(rsp_valid[k]), 32'd0);
    end
    access(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 10'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
